// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state encoding and widths for the CPU run controller
// Holds the run_state_t enum (also read by the LCD/LED display logic) and the
// tick counter width.
package cpu_run_ctrl_pkg;
    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } run_state_t;
    localparam int TICK_CNT_W = 16;
    localparam logic [1:0] ST_PAUSE = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;
endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// key_debounce: synchronise and debounce an active-low push-button, pulse once per press
// Ports:
//   clock    board clock
//   reset    asynchronous active-low reset (filter returns to the released level)
//   key_n_i  raw active-low key, asynchronous to clock
//   press_o  one-cycle pulse on an accepted press (high-to-low); releases give none
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync1_q, sync2_q, stable_q, press_q, accept;
    logic [CW-1:0] cnt_q, cnt_d;
    // A new level wins once it has differed from the accepted level for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    assign accept = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign cnt_d  = (sync2_q == stable_q || accept) ? '0 : cnt_q + 1'b1;
    assign press_o = press_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= accept ? sync2_q : stable_q;
            cnt_q    <= cnt_d;
            press_q  <= accept && !sync2_q;
        end
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: generates the one-cycle CPU clock enable (run / pause / step / breakpoint)
// Optional feature macro: CPU_RUN_CTRL_BREAKPOINT_EN (PC-match breakpoint and BREAK state).
// Ports:
//   clock       board clock (CLOCK_50)
//   reset       asynchronous active-low reset
//   run_i       run switch, 1 = run, 0 = pause
//   step_key_n  raw active-low single-step key
//   pc          CPU program counter
//   bp_addr     breakpoint address
//   bp_enable   breakpoint compare enable
//   cpu_tick    registered one-cycle CPU enable
//   cpu_clock   prescaler MSB for the LED
//   state       current run_state_t encoding
//   halted      high while stopped at a breakpoint
//   tick_count  number of cpu_tick pulses issued (wraps)
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = 25,
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run_i,
    input  logic                  step_key_n,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] bp_addr,
    input  logic                  bp_enable,
    output logic                  cpu_tick,
    output logic                  cpu_clock,
    output logic [1:0]            state,
    output logic                  halted,
    output logic [TICK_CNT_W-1:0] tick_count
);
    run_state_t state_q, state_d;
    logic [DIV_WIDTH-1:0] pre_q, pre_d;
    logic [TICK_CNT_W-1:0] tick_count_q;
    logic tick_q, tick_d, armed_q, armed_d, step_pulse, bp_hit, run_go;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clock   (clock),
        .reset   (reset),
        .key_n_i (step_key_n),
        .press_o (step_pulse)
    );

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // armed keeps a breakpoint at the resume address from firing before
    // at least one instruction has executed.
    assign bp_hit = armed_q && bp_enable && (pc == bp_addr);
    assign halted = (state_q == BREAK);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_enable};
    assign bp_hit = 1'b0;
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        case (state_q)
            PAUSE: begin
                state_d = run_i ? RUN : (step_pulse ? STEP : PAUSE);
                armed_d = run_i ? 1'b0 : armed_q;
            end
            RUN: begin
                state_d = !run_i ? PAUSE : (bp_hit ? BREAK : RUN);
                armed_d = armed_q | tick_q;
            end
            STEP:  state_d = PAUSE;
            BREAK: state_d = step_pulse ? STEP : (!run_i ? PAUSE : BREAK);
        endcase
    end

    // The prescaler only advances while staying in RUN, so a wrap on the
    // cycle that leaves RUN is neither counted nor ticked.
    assign run_go = (state_q == RUN) && (state_d == RUN);
    assign pre_d  = run_go ? pre_q + 1'b1 : pre_q;
    assign tick_d = (run_go && &pre_q) || (state_d == STEP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= PAUSE;
            pre_q        <= '0;
            tick_q       <= 1'b0;
            armed_q      <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            tick_q       <= tick_d;
            armed_q      <= armed_d;
            tick_count_q <= tick_count_q + TICK_CNT_W'(tick_q);
        end
    end

    assign cpu_tick   = tick_q;
    assign cpu_clock  = pre_q[DIV_WIDTH-1];
    assign state      = state_q;
    assign tick_count = tick_count_q;
endmodule
